// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, idle high) feeding a small byte FIFO.
// Bytes leave on a valid/ready stream; framing errors and overruns are pulsed.
module uart_rx_fifo #(
   parameter int unsigned CLK_SAMPLES = 4,
   parameter int unsigned DEPTH       = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy,
   output logic                     frame_err,
   output logic                     overrun
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CW    = PTR_W + 1;
   localparam int unsigned CNT_W = $clog2(CLK_SAMPLES);
   localparam int unsigned HALF  = CLK_SAMPLES / 2 - 1;
   localparam int unsigned FULL  = CLK_SAMPLES - 1;

   if (CLK_SAMPLES < 4 || (CLK_SAMPLES % 2) != 0) begin : g_bad_samples
      $error("uart_rx_fifo: CLK_SAMPLES must be even and >= 4");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
   end

   typedef enum logic [2:0] {S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e              state_q, state_d;
   logic                sync1_q, sync1_d, rx_s_q, rx_s_d, prev_rx_q, prev_rx_d;
   logic [1:0]          sync_vld_q, sync_vld_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [7:0]          shreg_q, shreg_d;
   logic                push_q, push_d;
   logic [7:0]          mem_q [DEPTH];
   logic [7:0]          mem_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                valid_q, valid_d, busy_q, busy_d;
   logic                frame_err_q, frame_err_d, overrun_q, overrun_d;
   logic                pop, full, wr_en;

   // Receiver: synchronizer, start-edge detect and mid-bit sampling FSM.
   always_comb begin
      sync1_d     = rx;
      rx_s_d      = sync1_q;
      prev_rx_d   = rx_s_q;
      sync_vld_d  = {sync_vld_q[0], 1'b1};
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         // The reset value of rx_s is not a real line sample, so wait until the
         // synchronizer has refilled before trusting a high level.
         S_WAIT_IDLE: begin
            if (sync_vld_q[1] && rx_s_q) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (prev_rx_q && !rx_s_q) begin
               state_d = S_START;
               cnt_d   = CNT_W'(HALF);
            end
         end
         S_START: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!rx_s_q) begin
               state_d   = S_DATA;
               bit_idx_d = 3'd0;
               cnt_d     = CNT_W'(FULL);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               shreg_d[bit_idx_q] = rx_s_q;
               cnt_d              = CNT_W'(FULL);
               if (bit_idx_q == 3'd7) state_d = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         S_STOP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rx_s_q) begin
               push_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               frame_err_d = 1'b1;
               state_d     = S_WAIT_IDLE;
            end
         end
         default: state_d = S_WAIT_IDLE;
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_WAIT_IDLE);
   end

   // FIFO: a full FIFO still accepts a push when a pop happens in the same cycle.
   always_comb begin
      pop       = valid_q && out_ready;
      full      = (count_q == CW'(DEPTH));
      wr_en     = push_q && (!full || pop);
      overrun_d = push_q && full && !pop;
      mem_d     = mem_q;
      if (wr_en) mem_d[wr_ptr_q] = shreg_q;
      wr_ptr_d  = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d   = count_q;
      if (wr_en && !pop)      count_d = count_q + CW'(1);
      else if (!wr_en && pop) count_d = count_q - CW'(1);
      valid_d   = (count_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         prev_rx_q   <= 1'b1;
         sync_vld_q  <= 2'b00;
         state_q     <= S_WAIT_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shreg_q     <= 8'h00;
         push_q      <= 1'b0;
         mem_q       <= '{default: 8'h00};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         rx_s_q      <= rx_s_d;
         prev_rx_q   <= prev_rx_d;
         sync_vld_q  <= sync_vld_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         push_q      <= push_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_data   = mem_q[rd_ptr_q];
   assign out_valid  = valid_q;
   assign fifo_count = count_q;
   assign busy       = busy_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (CLK_SAMPLES=4, DEPTH=4): latency, overrun,
// framing error, glitch rejection, mid-frame reset and full push+pop.
module tb_uart_rx_fifo;
   localparam int CS = 4;

   logic       clk, rst, rx, out_ready;
   logic [7:0] out_data;
   logic       out_valid, busy, frame_err, overrun;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;

   uart_rx_fifo #(.CLK_SAMPLES(CS), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fifo_count(fifo_count), .busy(busy),
      .frame_err(frame_err), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse tallies; the two flags must never coincide.
   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (frame_err || overrun) begin
         checks++;
         if (frame_err && overrun) begin
            errors++;
            $display("FAIL flag_overlap: frame_err=%b overrun=%b, required not both 1", frame_err, overrun);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives ncyc clocks of a frame {stop, data, start}; call and return at a negedge.
   task automatic drive_frame(input logic [7:0] b, input logic stop, input int ncyc);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < ncyc; i++) begin
         rx = f[i / CS];
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({out_valid, out_data, fifo_count, busy, frame_err, overrun} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b data=%h count=%0d busy=%b fe=%b ov=%b, required all 0",
                  out_valid, out_data, fifo_count, busy, frame_err, overrun);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if ({out_valid, fifo_count, busy} !== 5'd0) begin
         errors++;
         $display("FAIL idle_after_reset: valid=%b count=%0d busy=%b, required 0 0 0",
                  out_valid, fifo_count, busy);
      end
   endtask

   task automatic test_latency();
      out_ready = 1'b1;
      drive_frame(8'h55, 1'b1, 40);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL lat_p40_valid: got %b required 0", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55) begin
         errors++;
         $display("FAIL lat_p41: valid=%b data=%h, required 1 55", out_valid, out_data);
      end
      checks++;
      if (frame_err !== 1'b0 || fe_cnt !== 0) begin
         errors++;
         $display("FAIL lat_frame_err: fe=%b fe_cnt=%0d, required 0 0", frame_err, fe_cnt);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL lat_p42: valid=%b count=%0d, required 0 0", out_valid, fifo_count);
      end
      @(negedge clk);
   endtask

   task automatic test_overrun();
      logic [7:0] exp_b [4];
      int ov0;
      exp_b = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
      ov0 = ov_cnt;
      out_ready = 1'b0;
      drive_frame(8'hA5, 1'b1, 40);
      drive_frame(8'h3C, 1'b1, 40);
      drive_frame(8'hFF, 1'b1, 40);
      drive_frame(8'h00, 1'b1, 40);
      drive_frame(8'h11, 1'b1, 40);
      checks++;
      if (fifo_count !== 3'd4 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
         errors++;
         $display("FAIL ovr_full: count=%0d valid=%b data=%h, required 4 1 a5", fifo_count, out_valid, out_data);
      end
      @(posedge clk); #1;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_early: overrun=%b required 0", overrun);
      end
      @(posedge clk); #1;
      checks++;
      if (overrun !== 1'b1 || fifo_count !== 3'd4 || out_data !== 8'hA5) begin
         errors++;
         $display("FAIL ovr_pulse: overrun=%b count=%0d data=%h, required 1 4 a5", overrun, fifo_count, out_data);
      end
      @(posedge clk); #1;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_one_cycle: overrun=%b required 0", overrun);
      end
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_b[i]) begin
            errors++;
            $display("FAIL ovr_pop%0d: valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_b[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0 || ov_cnt - ov0 !== 1) begin
         errors++;
         $display("FAIL ovr_drained: valid=%b count=%0d pulses=%0d, required 0 0 1",
                  out_valid, fifo_count, ov_cnt - ov0);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL pop_empty: count=%0d required 0", fifo_count);
      end
   endtask

   task automatic test_frame_err();
      int fe0;
      fe0 = fe_cnt;
      out_ready = 1'b0;
      drive_frame(8'h7E, 1'b0, 40);
      @(posedge clk); #1;
      checks++;
      if (frame_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL fe_pulse: frame_err=%b busy=%b, required 1 0", frame_err, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL fe_one_cycle: frame_err=%b required 0", frame_err);
      end
      @(negedge clk);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fe_dropped: count=%0d valid=%b, required 0 0", fifo_count, out_valid);
      end
      drive_frame(8'h81, 1'b1, 40);
      repeat (2) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd1 || out_data !== 8'h81 || fe_cnt - fe0 !== 1) begin
         errors++;
         $display("FAIL fe_next_byte: count=%0d data=%h fe_pulses=%0d, required 1 81 1",
                  fifo_count, out_data, fe_cnt - fe0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_glitch();
      int fe0, ov0;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL glitch_start: busy=%b required 1", busy);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_reject: busy=%b required 0", busy);
      end
      repeat (45) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0 || fe_cnt !== fe0 || ov_cnt !== ov0) begin
         errors++;
         $display("FAIL glitch_quiet: count=%0d fe_delta=%0d ov_delta=%0d, required 0 0 0",
                  fifo_count, fe_cnt - fe0, ov_cnt - ov0);
      end
   endtask

   task automatic test_reset_midframe();
      int fe0;
      fe0 = fe_cnt;
      out_ready = 1'b0;
      drive_frame(8'h3C, 1'b1, 40);
      repeat (2) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL rst_queued: count=%0d required 1", fifo_count);
      end
      drive_frame(8'h99, 1'b1, 22);
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL rst_immediate: valid=%b count=%0d busy=%b data=%h, required 0 0 0 00",
                  out_valid, fifo_count, busy, out_data);
      end
      repeat (2) @(negedge clk);
      rx  = 1'b0;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      rx = 1'b1;
      repeat (60) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd0 || busy !== 1'b0 || fe_cnt !== fe0) begin
         errors++;
         $display("FAIL rst_low_line: count=%0d busy=%b fe_delta=%0d, required 0 0 0",
                  fifo_count, busy, fe_cnt - fe0);
      end
      drive_frame(8'h42, 1'b1, 40);
      repeat (2) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd1 || out_data !== 8'h42) begin
         errors++;
         $display("FAIL rst_then_42: count=%0d data=%h, required 1 42", fifo_count, out_data);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_b [4];
      int ov0;
      exp_b = '{8'h02, 8'h03, 8'h04, 8'h05};
      ov0 = ov_cnt;
      out_ready = 1'b0;
      drive_frame(8'h01, 1'b1, 40);
      drive_frame(8'h02, 1'b1, 40);
      drive_frame(8'h03, 1'b1, 40);
      drive_frame(8'h04, 1'b1, 40);
      drive_frame(8'h05, 1'b1, 40);
      checks++;
      if (fifo_count !== 3'd4 || out_data !== 8'h01) begin
         errors++;
         $display("FAIL fpp_full: count=%0d data=%h, required 4 01", fifo_count, out_data);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (fifo_count !== 3'd4 || overrun !== 1'b0 || ov_cnt !== ov0) begin
         errors++;
         $display("FAIL fpp_accept: count=%0d overrun=%b ov_delta=%0d, required 4 0 0",
                  fifo_count, overrun, ov_cnt - ov0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_b[i]) begin
            errors++;
            $display("FAIL fpp_pop%0d: valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_b[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fpp_drained: count=%0d valid=%b, required 0 0", fifo_count, out_valid);
      end
   endtask

   initial begin
      rst       = 1'b1;
      rx        = 1'b1;
      out_ready = 1'b0;
      test_reset();
      test_latency();
      test_overrun();
      test_frame_err();
      test_glitch();
      test_reset_midframe();
      test_full_push_pop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable UART receiver with an output byte FIFO. It is the DUT-side consumer of the serial line driven by the UART transactor's tx pin.
- Format: 8N1, LSB first, idle high, CLK_SAMPLES clocks per bit (same convention as the transactor).
- Received bytes are buffered in a small FIFO and presented on a valid/ready stream. Framing errors and overruns are flagged.

Parameters:
- CLK_SAMPLES, 4: clocks per bit. Must be even and >= 4; elaboration error otherwise.
- DEPTH, 4: FIFO entries. Must be a power of 2 and >= 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- out_data  output  8  FIFO head byte; valid only while out_valid=1.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts; pop occurs when out_valid && out_ready.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- busy  output  1  FSM is not in IDLE or WAIT_IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because the FIFO was full.

Behaviour:
- Reset values:
  - Outputs: out_valid=0, out_data=0, fifo_count=0, busy=0, frame_err=0, overrun=0.
  - Internal: both synchronizer flops =1, prev_rx=1, FSM=WAIT_IDLE, FIFO pointers=0.
  - Reset asserted mid-frame discards the partial byte and all FIFO contents.
- Input path: 2-flop synchronizer gives rx_s, then prev_rx <= rx_s. Start edge is prev_rx=1 && rx_s=0.
- FSM:
  - WAIT_IDLE: go to IDLE on the first cycle rx_s=1. This prevents a line held low through reset from being taken as a start bit.
  - IDLE: on start edge, go to START, cnt=CLK_SAMPLES/2-1.
  - START: count down to 0, then check rx_s.
    - rx_s=0: go to DATA, bit_idx=0, cnt=CLK_SAMPLES-1.
    - rx_s=1 (glitch): go to IDLE silently.
  - DATA: when cnt reaches 0, shift rx_s into shreg[bit_idx], reload cnt=CLK_SAMPLES-1. After bit 7, go to STOP.
  - STOP: when cnt reaches 0, sample rx_s.
    - rx_s=1: push shreg, go to IDLE.
    - rx_s=0: pulse frame_err, drop byte, go to WAIT_IDLE.
- Sample points, relative to the cycle the start edge is detected: start check at +CLK_SAMPLES/2; bit i at +CLK_SAMPLES/2 + (i+1)*CLK_SAMPLES; stop at +CLK_SAMPLES/2 + 9*CLK_SAMPLES.
- Latency: out_valid first reads 1 at posedge 2 + CLK_SAMPLES/2 + 9*CLK_SAMPLES + 1 after the first posedge that samples rx=0. That is posedge 41 for CLK_SAMPLES=4, counting from posedge 0. This applies when the FIFO is empty.
- Back-to-back frames: a start edge is accepted on the cycle immediately after the stop-bit sample; no extra idle time is needed.
- FIFO:
  - Registered storage. out_data is driven from the head entry combinationally from pointer and storage, with no extra read latency.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full with push and pop in the same cycle: push accepted, no overrun.
  - Full with push and no pop: byte dropped, overrun pulses, contents unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo DEPTH.
- out_data must be stable while out_valid=1 && out_ready=0.
- frame_err and overrun are never asserted in the same cycle, because frame_err means no push occurred.

Test Plan:
1. CLK_SAMPLES=4, out_ready=1; drive 0x55 framed (start, 8 bits LSB first, stop, 4 clocks each) -> out_valid high exactly at posedge 41 for one cycle, out_data=0x55, frame_err=0.
2. out_ready=0; send 0xA5, 0x3C, 0xFF, 0x00 back-to-back -> fifo_count=4; a fifth byte 0x11 gives a one-cycle overrun pulse. Then raise out_ready -> pops 0xA5, 0x3C, 0xFF, 0x00 in order, and 0x11 never appears.
3. Send 0x7E with the stop bit held low, then release the line high; then send 0x81 -> frame_err pulses once and 0x7E is absent; 0x81 is received correctly.
4. Low glitch on rx of 1 clock (shorter than CLK_SAMPLES/2) -> FSM returns to IDLE, no byte pushed, no error flags.
5. Assert rst in the middle of bit 4 of 0x99, with one byte already queued -> out_valid=0 and fifo_count=0 immediately. Hold rx low for 10 cycles after rst deasserts, then idle, then send 0x42 -> only 0x42 is received.
6. FIFO full and out_ready=1 on the same cycle a new byte's stop bit is sampled -> byte pushed, no overrun, fifo_count stays 4, ordering is preserved.
